// File: rtl/demux2_buf_pkg.sv
// Shared constants for the buffered 1-to-2 demultiplexer.
// Select encoding and default word width.
package demux2_buf_pkg;
    localparam int   BITWIDTH = 32;
    localparam logic SEL_A    = 1'b0;
    localparam logic SEL_B    = 1'b1;
endpackage

// File: rtl/demux2_buf_if.sv
// Producer-side and two consumer-side valid/ready channels of demux2_buf.
// The master modport is the environment; the slave modport is the block.
interface demux2_buf_if
    import demux2_buf_pkg::*;
#(
    parameter int bitwidth = BITWIDTH
);
    logic                in_valid;
    logic                in_ready;
    logic                in_sel;
    logic [bitwidth-1:0] in_data;
    logic                a_valid;
    logic                a_ready;
    logic [bitwidth-1:0] a_data;
    logic                b_valid;
    logic                b_ready;
    logic [bitwidth-1:0] b_data;
    logic [1:0]          a_count;
    logic [1:0]          b_count;

    modport master (
        output in_valid, in_sel, in_data, a_ready, b_ready,
        input  in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count
    );

    modport slave (
        input  in_valid, in_sel, in_data, a_ready, b_ready,
        output in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count
    );
endinterface

// File: rtl/demux2_buf_fifo2.sv
// Two-entry FIFO, registered output, no bypass: a push becomes visible next cycle.
// Accepts a push while full when a pop happens in the same cycle.
module fifo2
#(
    parameter int bitwidth = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic                pop,
    input  logic [bitwidth-1:0] wdata,
    output logic [bitwidth-1:0] rdata,
    output logic                full,
    output logic                empty,
    output logic [1:0]          count
);
    logic                rd_ptr_q, rd_ptr_d;
    logic                wr_ptr_q, wr_ptr_d;
    logic [1:0]          count_q, count_d;
    logic [bitwidth-1:0] mem_q [2];
    logic [bitwidth-1:0] mem_d [2];
    logic                do_push, do_pop;

    assign full    = (count_q == 2'd2);
    assign empty   = (count_q == 2'd0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

// File: rtl/demux2_buf.sv
// Routes each accepted word to branch A or B (select==1 -> B), one 2-deep FIFO per branch; 1 cycle latency.
// in_ready reflects only the selected branch, so a stalled branch never blocks the other.
module demux2_buf
    import demux2_buf_pkg::*;
#(
    parameter int bitwidth = BITWIDTH
) (
    input  logic         clk,
    input  logic         rst,
    demux2_buf_if.slave  bus
);
    logic sel_b;
    logic full_a, empty_a, full_b, empty_b;
    logic pop_a, pop_b, push_a, push_b;
    logic in_ready;

    // An unknown select falls through to A and can never reach B.
    always_comb begin
        sel_b = 1'b0;
        if (bus.in_sel == SEL_B) begin
            sel_b = 1'b1;
        end
    end

    assign pop_a    = bus.a_ready && !empty_a;
    assign pop_b    = bus.b_ready && !empty_b;
    assign in_ready = sel_b ? (!full_b || pop_b) : (!full_a || pop_a);
    assign push_a   = bus.in_valid && in_ready && !sel_b;
    assign push_b   = bus.in_valid && in_ready &&  sel_b;

    assign bus.in_ready = in_ready;
    assign bus.a_valid  = !empty_a;
    assign bus.b_valid  = !empty_b;

    fifo2 #(.bitwidth(bitwidth)) u_fifo_a (
        .clk   (clk),
        .rst   (rst),
        .push  (push_a),
        .pop   (pop_a),
        .wdata (bus.in_data),
        .rdata (bus.a_data),
        .full  (full_a),
        .empty (empty_a),
        .count (bus.a_count)
    );

    fifo2 #(.bitwidth(bitwidth)) u_fifo_b (
        .clk   (clk),
        .rst   (rst),
        .push  (push_b),
        .pop   (pop_b),
        .wdata (bus.in_data),
        .rdata (bus.b_data),
        .full  (full_b),
        .empty (empty_b),
        .count (bus.b_count)
    );
endmodule

// File: tb/tb_demux2_buf.sv
// Self-checking bench for demux2_buf: fixed vector table, directed corner sequences,
// and random traffic checked against a queue-based reference model.
module tb_demux2_buf;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    demux2_buf_if #(.bitwidth(W)) bus ();
    demux2_buf #(.bitwidth(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    typedef struct {
        logic        iv;
        logic        sel;
        logic [31:0] dat;
        logic        ar;
        logic        br;
        logic        e_rdy;
        logic [1:0]  e_ac;
        logic [1:0]  e_bc;
        logic [31:0] e_ad;
        logic [31:0] e_bd;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a branch can take a word if it has room, or will free a slot this cycle.
    function automatic logic m_ready(input logic sel_b, input logic ar, input logic br);
        if (sel_b) return (qb.size() < 2) || (br && qb.size() > 0);
        return (qa.size() < 2) || (ar && qa.size() > 0);
    endfunction

    task automatic model_check(input string tag);
        logic sel_b;
        sel_b = (bus.in_sel === 1'b1);
        chk({tag, ".in_ready"}, {31'd0, bus.in_ready}, {31'd0, m_ready(sel_b, bus.a_ready, bus.b_ready)});
        chk({tag, ".a_count"}, {30'd0, bus.a_count}, qa.size());
        chk({tag, ".b_count"}, {30'd0, bus.b_count}, qb.size());
        chk({tag, ".a_valid"}, {31'd0, bus.a_valid}, {31'd0, qa.size() > 0});
        chk({tag, ".b_valid"}, {31'd0, bus.b_valid}, {31'd0, qb.size() > 0});
        if (qa.size() > 0) chk({tag, ".a_data"}, bus.a_data, qa[0]);
        if (qb.size() > 0) chk({tag, ".b_data"}, bus.b_data, qb[0]);
    endtask

    // Drive at the falling edge, sample the settled outputs 1ns later.
    task automatic pre(input logic iv, input logic sel, input logic [31:0] dat,
                       input logic ar, input logic br, input string tag);
        @(negedge clk);
        bus.in_valid = iv;
        bus.in_sel   = sel;
        bus.in_data  = dat;
        bus.a_ready  = ar;
        bus.b_ready  = br;
        #1;
        model_check(tag);
    endtask

    task automatic post();
        logic sel_b, rdy;
        sel_b = (bus.in_sel === 1'b1);
        rdy   = m_ready(sel_b, bus.a_ready, bus.b_ready);
        @(posedge clk);
        if (bus.a_ready && qa.size() > 0) void'(qa.pop_front());
        if (bus.b_ready && qb.size() > 0) void'(qb.pop_front());
        if (bus.in_valid && rdy) begin
            if (sel_b) qb.push_back(bus.in_data);
            else       qa.push_back(bus.in_data);
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_sel   = 1'b0;
        bus.in_data  = '0;
        bus.a_ready  = 1'b1;
        bus.b_ready  = 1'b1;

        // Routing, then B backpressure with a mid-stall switch to A, then full-with-pop.
        tbl[0]  = '{1'b1, 1'b0, 32'h11, 1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 32'h0,  32'h0};
        tbl[1]  = '{1'b1, 1'b1, 32'h22, 1'b1, 1'b1, 1'b1, 2'd1, 2'd0, 32'h11, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 32'h33, 1'b1, 1'b1, 1'b1, 2'd0, 2'd1, 32'h0,  32'h22};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 2'd1, 2'd0, 32'h33, 32'h0};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 32'h0,  32'h0};
        tbl[5]  = '{1'b1, 1'b1, 32'h41, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 32'h0,  32'h0};
        tbl[6]  = '{1'b1, 1'b1, 32'h42, 1'b1, 1'b0, 1'b1, 2'd0, 2'd1, 32'h0,  32'h41};
        tbl[7]  = '{1'b1, 1'b1, 32'h43, 1'b1, 1'b0, 1'b0, 2'd0, 2'd2, 32'h0,  32'h41};
        tbl[8]  = '{1'b1, 1'b0, 32'h44, 1'b1, 1'b0, 1'b1, 2'd0, 2'd2, 32'h0,  32'h41};
        tbl[9]  = '{1'b1, 1'b0, 32'h45, 1'b1, 1'b0, 1'b1, 2'd1, 2'd2, 32'h44, 32'h41};
        tbl[10] = '{1'b1, 1'b1, 32'h43, 1'b1, 1'b1, 1'b1, 2'd1, 2'd2, 32'h45, 32'h41};
        tbl[11] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 2'd0, 2'd2, 32'h0,  32'h42};
        tbl[12] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 2'd0, 2'd1, 32'h0,  32'h43};
        tbl[13] = '{1'b0, 1'b0, 32'h0,  1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 32'h0,  32'h0};

        // Reset asserted mid-cycle takes effect without waiting for a clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst.a_valid",  {31'd0, bus.a_valid}, 32'd0);
        chk("rst.b_valid",  {31'd0, bus.b_valid}, 32'd0);
        chk("rst.a_count",  {30'd0, bus.a_count}, 32'd0);
        chk("rst.b_count",  {30'd0, bus.b_count}, 32'd0);
        chk("rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
        #5 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pre(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, "idle");
            post();
        end

        for (int i = 0; i < 14; i++) begin
            pre(tbl[i].iv, tbl[i].sel, tbl[i].dat, tbl[i].ar, tbl[i].br, "tbl_model");
            chk($sformatf("tbl%0d.in_ready", i), {31'd0, bus.in_ready}, {31'd0, tbl[i].e_rdy});
            chk($sformatf("tbl%0d.a_count", i), {30'd0, bus.a_count}, {30'd0, tbl[i].e_ac});
            chk($sformatf("tbl%0d.b_count", i), {30'd0, bus.b_count}, {30'd0, tbl[i].e_bc});
            if (tbl[i].e_ac != 2'd0) chk($sformatf("tbl%0d.a_data", i), bus.a_data, tbl[i].e_ad);
            if (tbl[i].e_bc != 2'd0) chk($sformatf("tbl%0d.b_data", i), bus.b_data, tbl[i].e_bd);
            post();
        end

        // Unknown select must land on A only.
        pre(1'b1, 1'bx, 32'hDEADBEEF, 1'b0, 1'b0, "xsel");
        post();
        pre(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, "xsel_hold");
        chk("xsel.a_data",  bus.a_data, 32'hDEADBEEF);
        chk("xsel.b_count", {30'd0, bus.b_count}, 32'd0);
        post();
        pre(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, "xsel_drain");
        post();

        // Fill A, then stream 10 words through it while full to exercise pointer wrap.
        pre(1'b1, 1'b0, 32'h100, 1'b0, 1'b1, "fill");
        post();
        pre(1'b1, 1'b0, 32'h101, 1'b0, 1'b1, "fill");
        post();
        for (int i = 0; i < 10; i++) begin
            pre(1'b1, 1'b0, 32'h200 + i, 1'b1, 1'b1, "stream");
            chk("stream.a_count",  {30'd0, bus.a_count}, 32'd2);
            chk("stream.in_ready", {31'd0, bus.in_ready}, 32'd1);
            post();
        end
        for (int i = 0; i < 3; i++) begin
            pre(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, "stream_drain");
            post();
        end

        for (int i = 0; i < 400; i++) begin
            pre(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), "rand");
            post();
        end

        // Reset mid-burst discards queued words on both branches.
        for (int i = 0; i < 4; i++) begin
            pre(1'b1, 1'(i / 2), 32'hA0 + i, 1'b0, 1'b0, "burst");
            post();
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mrst.a_count", {30'd0, bus.a_count}, 32'd0);
        chk("mrst.b_count", {30'd0, bus.b_count}, 32'd0);
        chk("mrst.a_valid", {31'd0, bus.a_valid}, 32'd0);
        chk("mrst.b_valid", {31'd0, bus.b_valid}, 32'd0);
        qa.delete();
        qb.delete();
        #4 rst = 1'b0;
        pre(1'b1, 1'b1, 32'h55, 1'b1, 1'b1, "post_rst");
        chk("post_rst.in_ready", {31'd0, bus.in_ready}, 32'd1);
        post();
        pre(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, "post_rst_out");
        chk("post_rst.b_valid", {31'd0, bus.b_valid}, 32'd1);
        chk("post_rst.b_data",  bus.b_data, 32'h55);
        chk("post_rst.a_valid", {31'd0, bus.a_valid}, 32'd0);
        post();
        for (int i = 0; i < 3; i++) begin
            pre(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, "final_idle");
            post();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
